// File: rtl/jump_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// jump_fetch_ctrl_if
//
// Purpose: bundles the fetch controller's bus signals. These are the stall and
// resume controls, the instruction memory address and returned word, and the
// valid-qualified output toward the IF/ID register.
//
// Parameters:
//   RegWidth    instruction / PC width
//   CountWidth  width of the taken-jump counter
//
// Modports:
//   master  the fetch controller. It receives stall, resume and instr_in, and
//           drives the memory address and all IF/ID-side outputs.
//   slave   the environment around it: the instruction memory, the pipeline
//           control and the IF/ID register.
// -----------------------------------------------------------------------------
interface jump_fetch_ctrl_if #(
    parameter int RegWidth   = 16,
    parameter int CountWidth = 8
);
    logic                  stall;
    logic                  resume;
    logic [RegWidth-1:0]   instr_in;
    logic [RegWidth-1:0]   imem_addr;
    logic [RegWidth-1:0]   instr_out;
    logic [RegWidth-1:0]   instr_pc;
    logic                  instr_valid;
    logic                  take_jump;
    logic [RegWidth-1:0]   jump_address;
    logic                  halted;
    logic [CountWidth-1:0] jump_count;

    modport master (
        input  stall, resume, instr_in,
        output imem_addr, instr_out, instr_pc, instr_valid,
               take_jump, jump_address, halted, jump_count
    );

    modport slave (
        output stall, resume, instr_in,
        input  imem_addr, instr_out, instr_pc, instr_valid,
               take_jump, jump_address, halted, jump_count
    );
endinterface

// File: rtl/jump_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// jump_fetch_ctrl
//
// Purpose: instruction-fetch controller for the IF stage. It owns the program
// counter and drives a synchronous (1-cycle latency) instruction memory. It
// decodes each returned word for jump and halt, redirects the PC on a taken
// jump, and squashes the single wrong-path word that follows the jump. It
// freezes on halt until resumed and honours a downstream stall. It also keeps
// a saturating count of taken jumps.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   jump_fetch_ctrl_if.master, which carries:
//     stall        hold all state and outputs this cycle
//     resume       leave HALT (only looked at in HALT)
//     instr_in     memory word for the address presented one cycle earlier
//     imem_addr    address presented to memory (combinational from state)
//     instr_out    registered instruction for decode
//     instr_pc     registered address of instr_out
//     instr_valid  instr_out is a real, non-squashed instruction
//     take_jump    one-cycle registered pulse per taken jump
//     jump_address registered target of the last taken jump
//     halted       high while in HALT
//     jump_count   saturating count of taken jumps
// -----------------------------------------------------------------------------
module jump_fetch_ctrl #(
    parameter int                  RegWidth   = 16,
    parameter int                  OpWidth    = 4,
    parameter logic [OpWidth-1:0]  JumpOpcode = 4'b1110,
    parameter logic [RegWidth-1:0] HaltWord   = 16'h0000,
    parameter int                  JumpMode   = 0,
    parameter logic [RegWidth-1:0] ResetPC    = 16'h0000,
    parameter int                  CountWidth = 8
) (
    input  logic                clk,
    input  logic                rst,
    jump_fetch_ctrl_if.master   bus
);

    localparam int FieldWidth = RegWidth - OpWidth;

    // REFILL: the word arriving now belongs to a stale address, so drop it.
    // RUN:    the word arriving now belongs to fetch_pc.
    // HALT:   frozen on the halt word until resume.
    localparam logic [1:0] REFILL = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] HALT   = 2'd2;

    logic [1:0]            state;
    logic [RegWidth-1:0]   pc;        // next address to fetch
    logic [RegWidth-1:0]   fetch_pc;  // address of the word now on instr_in

    logic [OpWidth-1:0]    opcode;
    logic [FieldWidth-1:0] field;
    logic                  is_halt;
    logic                  is_jump;
    logic [RegWidth-1:0]   pc_inc;
    logic [RegWidth-1:0]   fetch_inc;
    logic [RegWidth-1:0]   target;

    // Decode of the returned word and jump target computation.
    // NOTE: every signal gets a value on every path through always_comb;
    // a path that leaves one unassigned infers a latch.
    always_comb begin
        opcode    = bus.instr_in[RegWidth-1 -: OpWidth];
        field     = bus.instr_in[FieldWidth-1:0];
        is_halt   = (bus.instr_in == HaltWord);
        // The halt word wins even if its top bits happen to match JumpOpcode.
        is_jump   = !is_halt && (opcode == JumpOpcode);
        pc_inc    = pc + RegWidth'(1);
        fetch_inc = fetch_pc + RegWidth'(1);
        if (JumpMode == 0) begin
            // Page-absolute: keep the page bits of the jump's own address.
            target = {fetch_pc[RegWidth-1 -: OpWidth], field};
        end else begin
            // PC-relative to the word after the jump. This wraps modulo
            // 2^RegWidth.
            target = fetch_inc + {{OpWidth{field[FieldWidth-1]}}, field};
        end
    end

    // While stalled in RUN, or halted, re-present fetch_pc. The memory then
    // keeps returning the word we are holding, and nothing is skipped on
    // release.
    assign bus.imem_addr = ((state == HALT) || ((state == RUN) && bus.stall))
                           ? fetch_pc : pc;

    // NOTE: sequential state uses non-blocking assignments only, so that
    // every register samples its inputs from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= REFILL;
            pc               <= ResetPC;
            fetch_pc         <= ResetPC;
            bus.instr_out    <= '0;
            bus.instr_pc     <= '0;
            bus.instr_valid  <= 1'b0;
            bus.take_jump    <= 1'b0;
            bus.jump_address <= '0;
            bus.halted       <= 1'b0;
            bus.jump_count   <= '0;
        end else if (!bus.stall) begin
            case (state)
                REFILL: begin
                    // The word on instr_in is wrong-path or stale: emit a bubble.
                    bus.instr_valid <= 1'b0;
                    bus.take_jump   <= 1'b0;
                    fetch_pc        <= pc;
                    pc              <= pc_inc;
                    state           <= RUN;
                end

                RUN: begin
                    if (is_halt) begin
                        // pc and fetch_pc hold, so imem_addr parks on the
                        // halt word.
                        bus.instr_valid <= 1'b0;
                        bus.take_jump   <= 1'b0;
                        bus.halted      <= 1'b1;
                        state           <= HALT;
                    end else if (is_jump) begin
                        bus.instr_out    <= bus.instr_in;
                        bus.instr_pc     <= fetch_pc;
                        bus.instr_valid  <= 1'b1;
                        bus.take_jump    <= 1'b1;
                        bus.jump_address <= target;
                        pc               <= target;
                        if (bus.jump_count != '1) begin
                            bus.jump_count <= bus.jump_count + CountWidth'(1);
                        end
                        // The word fetched this cycle is sequential, not the
                        // target. REFILL drops it.
                        state            <= REFILL;
                    end else begin
                        bus.instr_out   <= bus.instr_in;
                        bus.instr_pc    <= fetch_pc;
                        bus.instr_valid <= 1'b1;
                        bus.take_jump   <= 1'b0;
                        fetch_pc        <= pc;
                        pc              <= pc_inc;
                    end
                end

                HALT: begin
                    bus.instr_valid <= 1'b0;
                    bus.take_jump   <= 1'b0;
                    if (bus.resume) begin
                        pc         <= fetch_inc;
                        bus.halted <= 1'b0;
                        state      <= REFILL;
                    end
                end

                default: begin
                    // Unused encoding: recover through a refill.
                    bus.instr_valid <= 1'b0;
                    bus.take_jump   <= 1'b0;
                    state           <= REFILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jump_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_jump_fetch_ctrl
//
// Two controllers run side by side with their own synchronous memories:
//   dut_a: ResetPC=8,     page-absolute jumps, 8-bit counter
//   dut_b: ResetPC=16'h10, PC-relative jumps,  2-bit counter
// Each memory holds {4'h1, addr[11:0]} by default, which is neither a jump nor
// a halt. Selected words are overwritten per scenario. Every expected value
// below is hand-derived from the cycle behaviour of the fetch controller.
// -----------------------------------------------------------------------------
module tb_jump_fetch_ctrl;

    logic clk;
    logic rst;

    int tests_run    = 0;
    int tests_failed = 0;

    jump_fetch_ctrl_if #(.RegWidth(16), .CountWidth(8)) bus_a ();
    jump_fetch_ctrl_if #(.RegWidth(16), .CountWidth(2)) bus_b ();

    jump_fetch_ctrl #(
        .RegWidth(16), .OpWidth(4), .JumpOpcode(4'b1110), .HaltWord(16'h0000),
        .JumpMode(0), .ResetPC(16'h0008), .CountWidth(8)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    jump_fetch_ctrl #(
        .RegWidth(16), .OpWidth(4), .JumpOpcode(4'b1110), .HaltWord(16'h0000),
        .JumpMode(1), .ResetPC(16'h0010), .CountWidth(2)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    logic [15:0] mem_a [0:65535];
    logic [15:0] mem_b [0:65535];

    // Synchronous instruction memories with 1-cycle latency.
    always @(posedge clk) bus_a.instr_in <= mem_a[bus_a.imem_addr];
    always @(posedge clk) bus_b.instr_in <= mem_b[bus_b.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_on();
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic reset_off();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem_a[i] = 16'h1000 | 16'(i[11:0]);
            mem_b[i] = 16'h1000 | 16'(i[11:0]);
        end
        rst          = 1'b1;
        bus_a.stall  = 1'b0;
        bus_a.resume = 1'b0;
        bus_b.stall  = 1'b0;
        bus_b.resume = 1'b0;
        #1;

        // ---------------- reset state ----------------
        check("a_rst_valid", 32'(bus_a.instr_valid), 32'h0);
        check("a_rst_instr_pc", 32'(bus_a.instr_pc), 32'h0);
        check("a_rst_instr_out", 32'(bus_a.instr_out), 32'h0);
        check("a_rst_imem_addr", 32'(bus_a.imem_addr), 32'h0008);
        check("a_rst_halted", 32'(bus_a.halted), 32'h0);
        reset_off();

        // ---------------- sequential fetch from ResetPC=8 ----------------
        tick();
        check("a_edge1_valid", 32'(bus_a.instr_valid), 32'h0);
        tick();
        check("a_edge2_valid", 32'(bus_a.instr_valid), 32'h1);
        check("a_edge2_pc", 32'(bus_a.instr_pc), 32'h0008);
        check("a_edge2_out", 32'(bus_a.instr_out), 32'h1008);
        tick();
        check("a_edge3_pc", 32'(bus_a.instr_pc), 32'h0009);
        tick();
        check("a_edge4_pc", 32'(bus_a.instr_pc), 32'h000A);

        // ---------------- stall for 3 cycles in RUN ----------------
        bus_a.stall = 1'b1;
        #1;
        check("a_stall_addr", 32'(bus_a.imem_addr), 32'h000B);
        repeat (3) begin
            tick();
            check("a_stall_pc", 32'(bus_a.instr_pc), 32'h000A);
            check("a_stall_valid", 32'(bus_a.instr_valid), 32'h1);
            check("a_stall_out", 32'(bus_a.instr_out), 32'h100A);
            check("a_stall_addr_hold", 32'(bus_a.imem_addr), 32'h000B);
        end
        bus_a.stall = 1'b0;
        tick();
        check("a_unstall_pc0", 32'(bus_a.instr_pc), 32'h000B);
        check("a_unstall_out0", 32'(bus_a.instr_out), 32'h100B);
        tick();
        check("a_unstall_pc1", 32'(bus_a.instr_pc), 32'h000C);

        // ---------------- page-absolute jumps, stall on pulse, halt ----------------
        mem_a[16'h0008] = 16'b1110001100111010;  // jump to 16'h033A
        mem_a[16'h033D] = 16'hE005;              // jump to 16'h0005
        mem_a[16'h0005] = 16'h0000;              // halt
        reset_on();
        check("a_rst2_valid", 32'(bus_a.instr_valid), 32'h0);
        check("a_rst2_pc", 32'(bus_a.instr_pc), 32'h0);
        reset_off();
        tick();
        tick();
        check("a_j1_out", 32'(bus_a.instr_out), 32'hE33A);
        check("a_j1_pc", 32'(bus_a.instr_pc), 32'h0008);
        check("a_j1_valid", 32'(bus_a.instr_valid), 32'h1);
        check("a_j1_take", 32'(bus_a.take_jump), 32'h1);
        check("a_j1_addr", 32'(bus_a.jump_address), 32'h033A);
        check("a_j1_count", 32'(bus_a.jump_count), 32'h1);
        tick();
        check("a_j1_bubble_valid", 32'(bus_a.instr_valid), 32'h0);
        check("a_j1_bubble_take", 32'(bus_a.take_jump), 32'h0);
        tick();
        check("a_j1_target_pc", 32'(bus_a.instr_pc), 32'h033A);
        check("a_j1_target_valid", 32'(bus_a.instr_valid), 32'h1);
        check("a_j1_target_out", 32'(bus_a.instr_out), 32'h133A);
        tick();
        tick();
        check("a_seq_pc", 32'(bus_a.instr_pc), 32'h033C);
        tick();
        check("a_j2_take", 32'(bus_a.take_jump), 32'h1);
        check("a_j2_addr", 32'(bus_a.jump_address), 32'h0005);
        check("a_j2_count", 32'(bus_a.jump_count), 32'h2);
        bus_a.stall = 1'b1;
        repeat (2) begin
            tick();
            check("a_j2_stall_take", 32'(bus_a.take_jump), 32'h1);
            check("a_j2_stall_count", 32'(bus_a.jump_count), 32'h2);
            check("a_j2_stall_pc", 32'(bus_a.instr_pc), 32'h033D);
        end
        bus_a.stall = 1'b0;
        tick();
        check("a_j2_bubble_take", 32'(bus_a.take_jump), 32'h0);
        check("a_j2_bubble_valid", 32'(bus_a.instr_valid), 32'h0);
        check("a_j2_count_once", 32'(bus_a.jump_count), 32'h2);
        tick();
        check("a_halt_halted", 32'(bus_a.halted), 32'h1);
        check("a_halt_valid", 32'(bus_a.instr_valid), 32'h0);
        check("a_halt_addr", 32'(bus_a.imem_addr), 32'h0005);
        repeat (10) begin
            tick();
            check("a_halt_hold_addr", 32'(bus_a.imem_addr), 32'h0005);
            check("a_halt_hold_halted", 32'(bus_a.halted), 32'h1);
            check("a_halt_hold_valid", 32'(bus_a.instr_valid), 32'h0);
        end
        bus_a.resume = 1'b1;
        tick();
        bus_a.resume = 1'b0;
        check("a_resume_halted", 32'(bus_a.halted), 32'h0);
        check("a_resume_valid0", 32'(bus_a.instr_valid), 32'h0);
        tick();
        check("a_resume_valid1", 32'(bus_a.instr_valid), 32'h0);
        tick();
        check("a_resume_pc", 32'(bus_a.instr_pc), 32'h0006);
        check("a_resume_valid", 32'(bus_a.instr_valid), 32'h1);
        check("a_resume_out", 32'(bus_a.instr_out), 32'h1006);

        // ---------------- PC-relative jumps, wrap, 2-bit saturation ----------------
        mem_b[16'h0010] = 16'hEFFE;  // 0x10 + 1 - 2      = 0x000F
        mem_b[16'h000F] = 16'hEFEF;  // 0x0F + 1 - 0x11   = 0xFFFF
        mem_b[16'hFFFF] = 16'hE000;  // 0xFFFF + 1        = 0x0000 (wrap)
        mem_b[16'h0000] = 16'hE000;  // -> 0x0001
        mem_b[16'h0001] = 16'hE000;  // -> 0x0002
        mem_b[16'h0003] = 16'hE000;  // -> 0x0004
        reset_on();
        check("b_rst_addr", 32'(bus_b.imem_addr), 32'h0010);
        check("b_rst_count", 32'(bus_b.jump_count), 32'h0);
        reset_off();
        tick();
        tick();
        check("b_j1_addr", 32'(bus_b.jump_address), 32'h000F);
        check("b_j1_pc", 32'(bus_b.instr_pc), 32'h0010);
        check("b_j1_count", 32'(bus_b.jump_count), 32'h1);
        tick();
        tick();
        check("b_j2_pc", 32'(bus_b.instr_pc), 32'h000F);
        check("b_j2_addr", 32'(bus_b.jump_address), 32'hFFFF);
        check("b_j2_count", 32'(bus_b.jump_count), 32'h2);
        tick();
        tick();
        check("b_j3_pc", 32'(bus_b.instr_pc), 32'hFFFF);
        check("b_j3_wrap_addr", 32'(bus_b.jump_address), 32'h0000);
        check("b_j3_count", 32'(bus_b.jump_count), 32'h3);
        tick();
        tick();
        check("b_j4_addr", 32'(bus_b.jump_address), 32'h0001);
        check("b_j4_count_sat", 32'(bus_b.jump_count), 32'h3);
        tick();
        tick();
        check("b_j5_addr", 32'(bus_b.jump_address), 32'h0002);
        check("b_j5_count_sat", 32'(bus_b.jump_count), 32'h3);
        tick();
        tick();
        check("b_after_pc", 32'(bus_b.instr_pc), 32'h0002);
        check("b_after_out", 32'(bus_b.instr_out), 32'h1002);
        tick();
        check("b_j6_take", 32'(bus_b.take_jump), 32'h1);
        check("b_j6_addr", 32'(bus_b.jump_address), 32'h0004);

        // ---------------- asynchronous reset in the middle of a refill ----------------
        reset_on();
        check("b_async_valid", 32'(bus_b.instr_valid), 32'h0);
        check("b_async_take", 32'(bus_b.take_jump), 32'h0);
        check("b_async_jaddr", 32'(bus_b.jump_address), 32'h0);
        check("b_async_count", 32'(bus_b.jump_count), 32'h0);
        check("b_async_pc", 32'(bus_b.instr_pc), 32'h0);
        check("b_async_out", 32'(bus_b.instr_out), 32'h0);
        check("b_async_halted", 32'(bus_b.halted), 32'h0);
        check("b_async_addr", 32'(bus_b.imem_addr), 32'h0010);
        reset_off();
        tick();
        tick();
        check("b_restart_pc", 32'(bus_b.instr_pc), 32'h0010);
        check("b_restart_count", 32'(bus_b.jump_count), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
